// File: rtl/tag_return_arbiter.sv
// Tag-return arbiter: one holding register per retire source, drained
// round-robin into the single tag FIFO write port at one tag per cycle.
// A source whose entry drains this cycle may reload in the same cycle.
// Loading a stalled source drops the tag and raises a sticky overrun flag.
module tag_return_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTRW  = 2,
    parameter int DSIZE = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ*DSIZE-1:0]   Ret_Tag,
    input  logic [NREQ-1:0]         Ret_Valid,
    output logic [NREQ-1:0]         Ret_Stall,
    input  logic                    tagFifo_full,
    output logic [DSIZE-1:0]        RB_Tag,
    output logic                    RB_Tag_Valid,
    output logic [PTRW-1:0]         Grant_Id,
    output logic [PTRW:0]           Pending_Cnt,
    output logic                    Ret_Overrun
);

    localparam int CNTW = PTRW + 1;

    logic [NREQ-1:0]   hold_valid_r;
    logic [DSIZE-1:0]  hold_tag_r [NREQ];
    logic [PTRW-1:0]   rr_ptr_r;
    logic              overrun_r;

    logic [PTRW-1:0]   winner_s;
    logic              grant_any_s;
    logic [NREQ-1:0]   drain_s;
    logic [NREQ-1:0]   stall_s;
    logic [PTRW-1:0]   ptr_next_s;
    logic [CNTW-1:0]   pend_s;

    // Rotating-priority search: the occupied source closest to rr_ptr (wrapping) wins.
    always_comb begin
        int  best_d;
        int  d;
        logic take;
        winner_s = {PTRW{1'b0}};
        best_d   = NREQ;
        d        = 0;
        take     = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            d        = (j >= int'(rr_ptr_r)) ? (j - int'(rr_ptr_r))
                                              : (j + NREQ - int'(rr_ptr_r));
            take     = hold_valid_r[j] && (d < best_d);
            winner_s = take ? PTRW'(j) : winner_s;
            best_d   = take ? d : best_d;
        end
    end

    // Grant qualification, per-source drain/stall, next pointer and occupancy count.
    always_comb begin
        grant_any_s = (|hold_valid_r) && !tagFifo_full;
        drain_s     = {NREQ{1'b0}};
        stall_s     = {NREQ{1'b0}};
        pend_s      = {CNTW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            drain_s[i] = grant_any_s && (winner_s == PTRW'(i));
            stall_s[i] = hold_valid_r[i] && !drain_s[i];
            pend_s     = pend_s + CNTW'(hold_valid_r[i]);
        end
        if (winner_s == PTRW'(NREQ - 1)) begin
            ptr_next_s = {PTRW{1'b0}};
        end else begin
            ptr_next_s = winner_s + PTRW'(1'b1);
        end
    end

    // FIFO-side outputs: the winning tag when a write happens, zero otherwise.
    always_comb begin
        RB_Tag_Valid = grant_any_s;
        if (grant_any_s) begin
            RB_Tag   = hold_tag_r[winner_s];
            Grant_Id = winner_s;
        end else begin
            RB_Tag   = {DSIZE{1'b0}};
            Grant_Id = rr_ptr_r;
        end
        Ret_Stall   = stall_s;
        Pending_Cnt = pend_s;
        Ret_Overrun = overrun_r;
    end

    // Holding registers: load when not stalled (including drain+reload), else clear on drain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid_r <= {NREQ{1'b0}};
            for (int i = 0; i < NREQ; i++) begin
                hold_tag_r[i] <= {DSIZE{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (Ret_Valid[i] && !stall_s[i]) begin
                    hold_valid_r[i] <= 1'b1;
                    hold_tag_r[i]   <= Ret_Tag[i*DSIZE +: DSIZE];
                end else if (drain_s[i]) begin
                    hold_valid_r[i] <= 1'b0;
                end else begin
                    hold_valid_r[i] <= hold_valid_r[i];
                end
            end
        end
    end

    // Round-robin pointer advances past the winner only when a write happens.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= {PTRW{1'b0}};
        end else if (grant_any_s) begin
            rr_ptr_r <= ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Sticky overrun: any source presenting a tag while stalled loses it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (|(Ret_Valid & stall_s)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule

// File: tb/tb_tag_return_arbiter.sv
// Bench for tag_return_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_tag_return_arbiter;

    localparam int NREQ  = 4;
    localparam int PTRW  = 2;
    localparam int DSIZE = 5;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ*DSIZE-1:0] Ret_Tag = '0;
    logic [NREQ-1:0]       Ret_Valid = '0;
    logic [NREQ-1:0]       Ret_Stall;
    logic                  tagFifo_full = 1'b0;
    logic [DSIZE-1:0]      RB_Tag;
    logic                  RB_Tag_Valid;
    logic [PTRW-1:0]       Grant_Id;
    logic [PTRW:0]         Pending_Cnt;
    logic                  Ret_Overrun;

    tag_return_arbiter #(.NREQ(NREQ), .PTRW(PTRW), .DSIZE(DSIZE)) dut (
        .clock        (clock),
        .reset        (reset),
        .Ret_Tag      (Ret_Tag),
        .Ret_Valid    (Ret_Valid),
        .Ret_Stall    (Ret_Stall),
        .tagFifo_full (tagFifo_full),
        .RB_Tag       (RB_Tag),
        .RB_Tag_Valid (RB_Tag_Valid),
        .Grant_Id     (Grant_Id),
        .Pending_Cnt  (Pending_Cnt),
        .Ret_Overrun  (Ret_Overrun)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_v [NREQ];
    int         m_t [NREQ];
    int         m_ptr = 0;
    bit         m_ovr = 1'b0;
    int         m_acc = 0;
    int         m_wr_dut = 0;
    int         e_w;
    bit         e_ga;
    int         e_pend;
    logic [3:0] e_stall;

    // Compare DUT to model on every falling edge, then advance the model to the next rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                m_v[i] = 1'b0;
                m_t[i] = 0;
            end
            m_ptr = 0; m_ovr = 1'b0; m_acc = 0; m_wr_dut = 0;
        end
        e_w = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (e_w < 0 && m_v[(m_ptr + k) % NREQ]) e_w = (m_ptr + k) % NREQ;
        end
        e_ga    = (e_w >= 0) && !tagFifo_full;
        e_pend  = 0;
        e_stall = '0;
        for (int i = 0; i < NREQ; i++) begin
            e_pend     += int'(m_v[i]);
            e_stall[i]  = m_v[i] && !(e_ga && e_w == i);
        end
        cmp("rb_tag_valid", 32'(RB_Tag_Valid), 32'(e_ga));
        cmp("rb_tag",       32'(RB_Tag),       e_ga ? m_t[e_w] : 0);
        cmp("grant_id",     32'(Grant_Id),     e_ga ? e_w : m_ptr);
        cmp("ret_stall",    32'(Ret_Stall),    32'(e_stall));
        cmp("pending_cnt",  32'(Pending_Cnt),  e_pend);
        cmp("ret_overrun",  32'(Ret_Overrun),  32'(m_ovr));
        if (reset) begin
            if (RB_Tag_Valid === 1'b1) m_wr_dut++;
            for (int i = 0; i < NREQ; i++) begin
                if (Ret_Valid[i] && !e_stall[i]) begin
                    m_v[i] = 1'b1;
                    m_t[i] = int'(Ret_Tag[i*DSIZE +: DSIZE]);
                    m_acc++;
                end else if (Ret_Valid[i]) begin
                    m_ovr = 1'b1;
                end else if (e_ga && e_w == i) begin
                    m_v[i] = 1'b0;
                end
            end
            if (e_ga) m_ptr = (e_w + 1) % NREQ;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [3:0] v, input logic [19:0] t, input logic f);
        @(posedge clock);
        #1;
        Ret_Valid    = v;
        Ret_Tag      = t;
        tagFifo_full = f;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    int         t2_tag   [5] = '{3, 9, 17, 30, 0};
    int         t2_pend  [5] = '{4, 3, 2, 1, 0};
    logic [3:0] t2_stall [5] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Directed scenarios, random traffic, then mid-drain reset.
    initial begin
        reset = 1'b0;
        #22 reset = 1'b1;

        // Single tag from source 0.
        cyc(4'b0001, 20'd7, 1'b0);
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t1_valid", 32'(RB_Tag_Valid), 32'd1);
        cmp("t1_tag",   32'(RB_Tag),       32'd7);
        cmp("t1_gid",   32'(Grant_Id),     32'd0);
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t1_idle_valid", 32'(RB_Tag_Valid), 32'd0);
        cmp("t1_idle_pend",  32'(Pending_Cnt),  32'd0);

        // Bring rr_ptr back to 0 via source 3, then load all four at once.
        cyc(4'b1000, {5'd1, 15'd0}, 1'b0);
        cyc(4'b0000, 20'd0, 1'b0);
        cyc(4'b1111, {5'd30, 5'd17, 5'd9, 5'd3}, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b0000, 20'd0, 1'b0);
            at_neg();
            cmp("t2_valid", 32'(RB_Tag_Valid), (k < 4) ? 32'd1 : 32'd0);
            cmp("t2_tag",   32'(RB_Tag),       t2_tag[k]);
            cmp("t2_pend",  32'(Pending_Cnt),  t2_pend[k]);
            cmp("t2_stall", 32'(Ret_Stall),    32'(t2_stall[k]));
        end

        // Continuous traffic: every source reloads whenever it is not stalled.
        for (int k = 0; k < 9; k++) begin
            @(posedge clock);
            #1;
            tagFifo_full = 1'b0;
            Ret_Valid    = ~Ret_Stall;
            Ret_Tag      = 20'($urandom);
            at_neg();
            if (k > 0) begin
                cmp("t3_grant", 32'(Grant_Id),     (k - 1) % 4);
                cmp("t3_valid", 32'(RB_Tag_Valid), 32'd1);
                if ((k - 1) % 4 == 2) begin
                    cmp("t3_stall2",  32'(Ret_Stall[2]), 32'd0);
                    cmp("t3_reload2", 32'(Ret_Valid[2]), 32'd1);
                end
            end
        end
        repeat (5) cyc(4'b0000, 20'd0, 1'b0);

        // FIFO full for three cycles with sources 1 and 3 held.
        cyc(4'b1010, {5'd5, 5'd0, 5'd21, 5'd0}, 1'b1);
        repeat (3) begin
            cyc(4'b0000, 20'd0, 1'b1);
            at_neg();
            cmp("t4_full_valid", 32'(RB_Tag_Valid), 32'd0);
            cmp("t4_full_gid",   32'(Grant_Id),     32'd0);
            cmp("t4_full_stall", 32'(Ret_Stall),    32'b1010);
        end
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t4_first_gid", 32'(Grant_Id), 32'd1);
        cmp("t4_first_tag", 32'(RB_Tag),   32'd21);
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t4_second_gid", 32'(Grant_Id), 32'd3);
        cmp("t4_second_tag", 32'(RB_Tag),   32'd5);
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t4_done_valid", 32'(RB_Tag_Valid), 32'd0);

        // Overrun: source 0 held and stalled, then presents tag 12.
        cyc(4'b0001, 20'd8, 1'b1);
        cyc(4'b0001, 20'd12, 1'b1);
        at_neg();
        cmp("t5_stall0",   32'(Ret_Stall[0]), 32'd1);
        cmp("t5_ovr_pre",  32'(Ret_Overrun),  32'd0);
        cyc(4'b0000, 20'd0, 1'b1);
        at_neg();
        cmp("t5_ovr_set",  32'(Ret_Overrun),  32'd1);
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t5_tag_kept", 32'(RB_Tag),       32'd8);
        cmp("t5_valid",    32'(RB_Tag_Valid), 32'd1);
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t5_ovr_sticky", 32'(Ret_Overrun), 32'd1);

        // Randomized traffic with random FIFO back-pressure.
        repeat (400) begin
            @(posedge clock);
            #1;
            tagFifo_full = ($urandom_range(0, 9) < 3);
            #1;
            Ret_Tag   = 20'($urandom);
            Ret_Valid = 4'($urandom) & ~Ret_Stall;
            if ($urandom_range(0, 19) == 0) Ret_Valid = 4'($urandom);
        end
        repeat (6) cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("sb_pending_zero", 32'(Pending_Cnt), 32'd0);
        cmp("sb_writes_vs_accepts", m_wr_dut, m_acc);

        // Reset in the middle of a drain with three holds occupied.
        cyc(4'b0111, {5'd0, 5'd11, 5'd22, 5'd13}, 1'b1);
        cyc(4'b0000, 20'd0, 1'b0);
        at_neg();
        cmp("t6_pend_before", 32'(Pending_Cnt),  32'd3);
        cmp("t6_valid_before", 32'(RB_Tag_Valid), 32'd1);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        cmp("t6_rst_valid", 32'(RB_Tag_Valid), 32'd0);
        cmp("t6_rst_tag",   32'(RB_Tag),       32'd0);
        cmp("t6_rst_gid",   32'(Grant_Id),     32'd0);
        cmp("t6_rst_pend",  32'(Pending_Cnt),  32'd0);
        cmp("t6_rst_stall", 32'(Ret_Stall),    32'd0);
        cmp("t6_rst_ovr",   32'(Ret_Overrun),  32'd0);
        #10 reset = 1'b1;
        repeat (5) begin
            at_neg();
            cmp("t6_no_pulse", 32'(RB_Tag_Valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
